// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 command transmitter. Sends one byte (8 data bits, LSB
// first, then odd parity and stop) to the device over the shared
// open-collector ps2_clock/ps2_data lines. It inhibits the bus, issues the
// request-to-send, shifts bits out on device clock falling edges, checks the
// device ACK and reports the result. busy tells the receive path to ignore
// line activity while a transfer is in progress.
//
// Ports
//   clk_in        system clock
//   reset         asynchronous, active-high; releases both lines at once
//   ps2_clock_in  raw ps2_clock line level
//   ps2_data_in   raw ps2_data line level
//   tx_data       command byte, taken when tx_valid & tx_ready
//   tx_valid      request to send tx_data
//   tx_ready      high only while idle
//   ps2_clock_oe  1 = pull ps2_clock low
//   ps2_data_oe   1 = pull ps2_data low
//   busy          high whenever not idle
//   done          one-cycle pulse at the end of each transfer
//   ack_ok        with done: device ACK seen
//   error         with done: timeout or missing ACK
//
// Build option: define PS2_TX_GLITCH_FILTER_EN to pass the synchronized
// clock through an 8-sample stability filter before edge detection.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | lines released, waiting for tx_valid
// INHIBIT    | holding ps2_clock low to claim the bus
// REQ        | start bit on data, clock released, waiting for device clock
// XFER       | shifting data, parity and stop bits on falling edges
// ACK        | waiting for the falling edge that carries the device ACK
// WAIT_IDLE  | waiting for both lines to return high
// DONE       | one-cycle result cycle (done=1), then back to IDLE

module ps2_host_tx #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_XFER      = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [8:0]       shreg;
  logic [3:0]       idx;
  logic             clk_s1, clk_s2, data_s1, data_s2;
  logic             clk_line, clk_prev, fe;
  logic             in_to, to_hit;

  // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clock_in;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
    end
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic       clk_filt;
  logic [2:0] flt_cnt;

  // Filtered level flips only after 8 consecutive samples disagree with it.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      clk_filt <= 1'b1;
      flt_cnt  <= 3'd0;
    end else if (clk_s2 == clk_filt) begin
      flt_cnt <= 3'd0;
    end else if (flt_cnt == 3'd7) begin
      clk_filt <= clk_s2;
      flt_cnt  <= 3'd0;
    end else begin
      flt_cnt <= flt_cnt + 3'd1;
    end
  end

  assign clk_line = clk_filt;
`else
  assign clk_line = clk_s2;
`endif

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) clk_prev <= 1'b1;
    else       clk_prev <= clk_line;
  end

  assign fe = clk_prev & ~clk_line;

  // A falling edge in the same cycle as the timeout wins and clears the counter.
  assign in_to  = (state == ST_REQ) || (state == ST_XFER) ||
                  (state == ST_ACK) || (state == ST_WAIT_IDLE);
  assign to_hit = in_to && !fe && (cnt == TO_LAST);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      idx         <= 4'd0;
      ps2_data_oe <= 1'b0;
      ack_ok      <= 1'b0;
      error       <= 1'b0;
    end else if (to_hit) begin
      state       <= ST_DONE;
      cnt         <= '0;
      ps2_data_oe <= 1'b0;
      ack_ok      <= 1'b0;
      error       <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            shreg  <= {~^tx_data, tx_data};
            idx    <= 4'd0;
            cnt    <= '0;
            ack_ok <= 1'b0;
            error  <= 1'b0;
            state  <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt         <= '0;
            ps2_data_oe <= 1'b1;
            state       <= ST_REQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_REQ, ST_XFER: begin
          if (fe) begin
            cnt <= '0;
            if (idx < 4'd9) begin
              ps2_data_oe <= ~shreg[idx];
              idx         <= idx + 4'd1;
              state       <= ST_XFER;
            end else begin
              ps2_data_oe <= 1'b0;
              state       <= ST_ACK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ACK: begin
          if (fe) begin
            cnt    <= '0;
            ack_ok <= ~data_s2;
            state  <= ST_WAIT_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (fe) cnt <= '0;
          else    cnt <= cnt + 1'b1;
          if (clk_line && data_s2) begin
            error <= ~ack_ok;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          ps2_data_oe <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign ps2_clock_oe = (state == ST_INHIBIT);
  assign busy         = (state != ST_IDLE);
  assign tx_ready     = (state == ST_IDLE);
  assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with shortened inhibit/timeout and a fast device
// model. Expected frames and results are queued when a command is sent and
// checked when the device model captures the frame and when done pulses.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int TO   = 2000;
  localparam int HALF = 40;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       ps2_clock_in, ps2_data_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, ps2_clock_oe, ps2_data_oe, busy, done, ack_ok, error;
  logic       dev_clk_low  = 1'b0;
  logic       dev_data_low = 1'b0;

  int          total = 0;
  int          bad   = 0;
  logic [10:0] frame_q[$];
  logic [1:0]  res_q[$];
  logic [10:0] last_frame;

  always #5 clk_in = ~clk_in;

  // Open-collector bus: either side may pull low.
  assign ps2_clock_in = ~(ps2_clock_oe | dev_clk_low);
  assign ps2_data_in  = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ(50_000_000),
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .ps2_clock_in(ps2_clock_in),
    .ps2_data_in(ps2_data_in),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clock_oe(ps2_clock_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .done(done),
    .ack_ok(ack_ok),
    .error(error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Requests a transfer and follows the inhibit phase; returns in the first
  // cycle of REQ. tx_valid is held with other data while busy to show it is ignored.
  task automatic send(input logic [7:0] b, input bit with_frame, input logic exp_ack, input logic exp_err);
    int n;
    n = 0;
    @(negedge clk_in);
    while (!tx_ready && n < 5000) begin
      @(negedge clk_in);
      n++;
    end
    check("ready_before_send", tx_ready, 1);
    if (with_frame) frame_q.push_back({1'b1, ~^b, b, 1'b0});
    res_q.push_back({exp_ack, exp_err});
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk_in);
    tx_data = ~b;
    check("busy_after_accept", busy, 1);
    check("clk_oe_after_accept", ps2_clock_oe, 1);
    check("data_oe_in_inhibit", ps2_data_oe, 0);
    check("ack_cleared", ack_ok, 0);
    check("err_cleared", error, 0);
    n = 0;
    while (ps2_clock_oe && n < INH + 20) begin
      n++;
      @(negedge clk_in);
    end
    tx_valid = 1'b0;
    check("inhibit_len", n, INH);
    check("data_oe_at_req", ps2_data_oe, 1);
    check("clk_oe_at_req", ps2_clock_oe, 0);
  endtask

  // Device model: samples data while clock is high, then pulses clock low.
  // A full frame is 11 pulses; the 11th falling edge carries the ACK.
  task automatic device(input int pulses, input bit do_ack);
    logic [10:0] fr;
    int g;
    g  = 0;
    fr = '0;
    while (!(ps2_data_in == 1'b0 && ps2_clock_in == 1'b1) && g < 2000) begin
      @(negedge clk_in);
      g++;
    end
    check("dev_saw_req", (g < 2000), 1);
    for (int k = 0; k < pulses; k++) begin
      repeat (HALF) @(negedge clk_in);
      fr[k] = ps2_data_in;
      if (k == 10 && do_ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk_in);
      dev_clk_low = 1'b0;
    end
    if (pulses == 11) begin
      repeat (HALF) @(negedge clk_in);
      dev_data_low = 1'b0;
      last_frame   = fr;
      check("frame_q_size", frame_q.size(), 1);
      if (frame_q.size() > 0) check("frame", fr, frame_q.pop_front());
    end
  endtask

  task automatic wait_done(output int cyc);
    logic [1:0] r;
    cyc = 0;
    while (!done && cyc < TO + 500) begin
      @(negedge clk_in);
      cyc++;
    end
    check("done_seen", done, 1);
    check("res_q_size", res_q.size(), 1);
    if (res_q.size() > 0) begin
      r = res_q.pop_front();
      check("ack_ok", ack_ok, r[1]);
      check("error", error, r[0]);
    end
    check("clk_oe_at_done", ps2_clock_oe, 0);
    check("data_oe_at_done", ps2_data_oe, 0);
    check("busy_at_done", busy, 1);
    @(negedge clk_in);
    check("done_width", done, 0);
    check("busy_after_done", busy, 0);
    check("ready_after_done", tx_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int c;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    last_frame = '0;
    repeat (3) @(negedge clk_in);
    check("rst_clk_oe", ps2_clock_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack", ack_ok, 0);
    check("rst_err", error, 0);
    check("rst_ready", tx_ready, 1);
    reset = 1'b0;
    repeat (3) @(negedge clk_in);

    // 0xED with ACK
    fork
      begin send(8'hED, 1, 1'b1, 1'b0); wait_done(c); end
      device(11, 1);
    join
    check("frame_ed", last_frame, 11'b11111011010);
    repeat (10) @(negedge clk_in);
    check("ack_hold", ack_ok, 1);
    check("err_hold", error, 0);

    // 0x00: parity bit must be 1
    fork
      begin send(8'h00, 1, 1'b1, 1'b0); wait_done(c); end
      device(11, 1);
    join
    check("parity_00", last_frame[9], 1);

    // No ACK
    fork
      begin send(8'hF4, 1, 1'b0, 1'b1); wait_done(c); end
      device(11, 0);
    join
    repeat (5) @(negedge clk_in);
    check("err_hold_noack", error, 1);

    // Silent device: timeout TO cycles after REQ entry
    send(8'h55, 0, 1'b0, 1'b1);
    wait_done(c);
    check("timeout_cycles", c, TO);

    // Reset in the middle of bit 4 of 0xA5 (bit 4 = 0 so data is pulled low)
    fork
      send(8'hA5, 1, 1'b1, 1'b0);
      device(5, 0);
    join
    check("mid_busy", busy, 1);
    check("mid_data_oe_bit4", ps2_data_oe, 1);
    #2 reset = 1'b1;
    #1;
    check("rstmid_clk_oe", ps2_clock_oe, 0);
    check("rstmid_data_oe", ps2_data_oe, 0);
    check("rstmid_busy", busy, 0);
    frame_q.delete();
    res_q.delete();
    @(negedge clk_in);
    reset = 1'b0;
    repeat (3) @(negedge clk_in);

    fork
      begin send(8'hF4, 1, 1'b1, 1'b0); wait_done(c); end
      device(11, 1);
    join

    repeat (5) @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
